// File: rtl/pwm_pkg.sv
// Shared defaults and run-mode encoding for the PWM core.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned PERIOD_DEF = 255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// One-cycle pulse on each rising edge of sig_in, synchronous to Clock_in.
module edge_detect_rise (
    input  logic Clock_in,
    input  logic Reset,
    input  logic sig_in,
    output logic pulse_out
);

    logic sig_q;

    // Loading the live input during reset keeps an already-high input from
    // looking like a fresh edge on the first cycle after reset.
    always_ff @(posedge Clock_in) begin
        sig_q <= sig_in;
    end

    assign pulse_out = sig_in & ~sig_q & ~Reset;

endmodule

// File: rtl/pwm_generator.sv
// PWM core: tick-driven period counter, double-buffered duty word, registered compare output.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PERIOD = PERIOD_DEF
) (
    input  logic             Clock_in,
    input  logic             Reset,
    input  logic             Clock_div,
    input  logic             Enable,
    input  logic [CNT_W-1:0] Duty_in,
    input  logic             Duty_valid,
    output logic             Duty_ready,
    output logic             Pwm_out,
    output logic             Period_end
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD);

    logic             tick;
    pwm_state_e       state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_active_q, duty_active_d;
    logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;
    logic             commit;
    logic             accept;

    edge_detect_rise u_tick_edge (
        .Clock_in  (Clock_in),
        .Reset     (Reset),
        .sig_in    (Clock_div),
        .pulse_out (tick)
    );

    assign state  = Enable ? RUN : IDLE;
    assign accept = Duty_valid & ~pending_q;

    always_comb begin
        cnt_d         = cnt_q;
        duty_active_d = duty_active_q;
        duty_shadow_d = duty_shadow_q;
        pending_d     = pending_q;
        period_end_d  = 1'b0;
        commit        = 1'b0;
        pwm_d         = Enable & ({1'b0, cnt_q} < {1'b0, duty_active_q});

        if (state == IDLE) begin
            cnt_d  = '0;
            commit = pending_q;
        end else if (tick) begin
            if (cnt_q == TERM) begin
                cnt_d        = '0;
                period_end_d = 1'b1;
                commit       = pending_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // commit requires pending, accept requires not pending: never both
        if (commit) begin
            duty_active_d = duty_shadow_q;
            pending_d     = 1'b0;
        end else if (accept) begin
            duty_shadow_d = Duty_in;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            cnt_q         <= '0;
            duty_active_q <= '0;
            duty_shadow_q <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= 1'b0;
            period_end_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            duty_active_q <= duty_active_d;
            duty_shadow_q <= duty_shadow_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
        end
    end

    assign Duty_ready = ~pending_q;
    assign Pwm_out    = pwm_q;
    assign Period_end = period_end_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed scenarios plus random traffic vs. a reference model.
module tb_pwm_generator;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERIOD = 9;
    localparam int          TPER   = (PERIOD + 1) * 4;

    logic             clk = 1'b0;
    logic             rst, en, div, valid;
    logic [CNT_W-1:0] din;
    logic             rdy, pwm, pe;

    always #5 clk = ~clk;

    pwm_generator #(.CNT_W(CNT_W), .PERIOD(PERIOD)) dut (
        .Clock_in   (clk),
        .Reset      (rst),
        .Clock_div  (div),
        .Enable     (en),
        .Duty_in    (din),
        .Duty_valid (valid),
        .Duty_ready (rdy),
        .Pwm_out    (pwm),
        .Period_end (pe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: position within the period, active/requested duty.
    int m_pos, m_duty, m_shadow;
    bit m_pending, m_pwm, m_pe, m_divprev, m_valid = 0;
    bit div_auto = 1;
    int div_ctr  = 0;

    function automatic void model_edge();
        bit tick, was_pending;
        if (rst) begin
            m_divprev = div; m_pos = 0; m_duty = 0; m_shadow = 0;
            m_pending = 0; m_pwm = 0; m_pe = 0; m_valid = 1;
            return;
        end
        tick        = div && !m_divprev;
        m_divprev   = div;
        was_pending = m_pending;
        m_pwm       = en && (m_pos < m_duty);
        m_pe        = 0;
        if (!en) begin
            m_pos = 0;
            if (was_pending) begin m_duty = m_shadow; m_pending = 0; end
        end else if (tick) begin
            m_pos = (m_pos + 1) % (PERIOD + 1);
            if (m_pos == 0) begin
                m_pe = 1;
                if (was_pending) begin m_duty = m_shadow; m_pending = 0; end
            end
        end
        if (!was_pending && valid) begin
            m_shadow  = din;
            m_pending = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            check("pwm", pwm, m_pwm);
            check("period_end", pe, m_pe);
            check("ready", rdy, !m_pending);
        end
        if (div_auto) begin
            div_ctr++;
            if (div_ctr == 2) begin div_ctr = 0; div = ~div; end
        end
    endtask

    task automatic window(input int n, input int s1, input int v1, input int s2, input int v2,
                          output int hi, output int pes);
        hi = 0; pes = 0;
        for (int i = 0; i < n; i++) begin
            valid = (i == s1) || (i == s2);
            din   = (i == s2) ? CNT_W'(v2) : CNT_W'(v1);
            if (i == s2) check("second_valid_not_ready", rdy, 0);
            step();
            hi  += pwm;
            pes += pe;
        end
        valid = 0;
    endtask

    task automatic wait_pe(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = pe;
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_pos(input string tag, input int pos, input bit need_div, input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_pos == pos && (!need_div || div)) begin found = 1; break; end
            step();
        end
        check(tag, found, 1);
    endtask

    initial begin
        int hi, pes, tog;
        bit p;
        rst = 1; en = 1; div = 0; valid = 0; din = '0;

        // 1: reset, accept duty 3, commit at first wrap, 12/40 high
        step(); step();
        rst = 0;
        valid = 1; din = 4'd3;
        step();
        valid = 0;
        check("s1_ready_low", rdy, 0);
        wait_pe("s1_first_pe", 80);
        check("s1_ready_after_commit", rdy, 1);
        window(TPER, -1, 0, -1, 0, hi, pes);
        check("s1_high", hi, 12);
        check("s1_pe_count", pes, 1);

        // 2: duty 0 then 15 (above PERIOD)
        window(TPER, 0, 0, -1, 0, hi, pes);
        check("s2_prev_duty", hi, 12);
        window(TPER, 0, 15, -1, 0, hi, pes);
        check("s2_zero", hi, 0);
        check("s2_zero_pe", pes, 1);
        window(TPER, 0, 3, -1, 0, hi, pes);
        check("s2_full", hi, TPER);
        check("s2_full_pe", pes, 1);

        // 3: mid-period update, second request ignored
        window(TPER, 10, 7, 14, 12, hi, pes);
        check("s3_keep_old", hi, 12);
        window(TPER, -1, 0, -1, 0, hi, pes);
        check("s3_new", hi, 28);
        window(TPER, -1, 0, -1, 0, hi, pes);
        check("s3_ignored", hi, 28);

        // 4: disable with a pending duty
        valid = 1; din = 4'd9;
        step();
        valid = 0;
        wait_pos("s4_reach_pos5", 5, 0, 60);
        check("s4_pending", rdy, 0);
        en = 0;
        step();
        check("s4_pwm_off", pwm, 0);
        check("s4_committed", rdy, 1);
        check("s4_no_pe", pe, 0);
        step(); step();
        en = 1;
        wait_pe("s4_restart_pe", 80);
        window(TPER, -1, 0, -1, 0, hi, pes);
        check("s4_high", hi, 36);

        // 5: reset mid-period with Clock_div high, pending duty discarded
        wait_pos("s5_reach_pos6", 6, 0, 60);
        valid = 1; din = 4'd5;
        step();
        valid = 0;
        wait_pos("s5_reach_pos8", 8, 1, 60);
        rst = 1;
        step();
        rst = 0;
        check("s5_pwm", pwm, 0);
        check("s5_pe", pe, 0);
        check("s5_ready", rdy, 1);
        wait_pe("s5_pe_after_reset", 80);
        window(TPER, -1, 0, -1, 0, hi, pes);
        check("s5_discarded", hi, 0);

        // 6: Clock_div stuck low
        window(TPER, 0, 6, -1, 0, hi, pes);
        wait_pos("s6_reach_pos3", 3, 0, 60);
        div_auto = 0; div = 0;
        step();
        p = pwm; tog = 0; pes = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pes += pe;
            if (pwm !== p) tog++;
        end
        check("s6_no_pe", pes, 0);
        check("s6_stable", tog, 0);
        check("s6_level", p, 1);
        div_auto = 1; div_ctr = 0;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            din   = CNT_W'($urandom);
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 79) == 0) div_auto = ~div_auto;
            if (!div_auto && $urandom_range(0, 9) == 0) div = $urandom_range(0, 1);
            step();
        end
        rst = 0; valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
